// File: rtl/variance_calc.sv
// variance_calc: per-core normalisation-variance stage.
// Holds a double-buffered store of four integral and four squared-integral
// rectangle corners written by the variance loader.  On start it computes
// area*sqsum - sum^2 for the selected bank, clamps a negative result to zero,
// and holds the result until the classifier acknowledges it.
module variance_calc #(
  parameter int DATA_W = 32,
  parameter int SQ_W   = 48,
  parameter int AREA_W = 16,
  parameter int VAR_W  = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [1:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              weSQ_i,
  input  logic [1:0]        waddrSQ_i,
  input  logic [SQ_W-1:0]   wdataSQ_i,
  input  logic              dblBuf_i,
  input  logic              start_i,
  input  logic              bufSel_i,
  input  logic [AREA_W-1:0] area_i,
  input  logic              ack_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [VAR_W-1:0]  variance_o,
  output logic              negClamp_o
);

  // Corner index encoding inside each bank.
  localparam int CORNER_A = 0;  // top-left
  localparam int CORNER_B = 1;  // top-right
  localparam int CORNER_C = 2;  // bottom-left
  localparam int CORNER_D = 3;  // bottom-right

  typedef enum logic [2:0] {
    S_Reset = 3'd0,
    S_Ready = 3'd1,
    S_Sum   = 3'd2,
    S_Mul1  = 3'd3,
    S_Mul2  = 3'd4,
    S_Sub   = 3'd5,
    S_Done  = 3'd6
  } state_t;

  state_t state_q;

  // Registered outputs and latched request parameters.
  logic              ready_q;
  logic              done_q;
  logic [VAR_W-1:0]  variance_q;
  logic              negClamp_q;
  logic              sel_q;
  logic [AREA_W-1:0] area_q;

  // Corner store: [bank][corner].
  logic [DATA_W-1:0] int_q [0:1][0:3];
  logic [SQ_W-1:0]   sq_q  [0:1][0:3];

  // Datapath pipeline registers (multiplier operands, then products).
  logic [DATA_W-1:0] sum_q;
  logic [SQ_W-1:0]   sqsum_q;
  logic [VAR_W-1:0]  prod_area_q;
  logic [VAR_W-1:0]  prod_sum_q;

  // Next-state / combinational datapath values.
  logic              store_clr_d;
  logic [DATA_W-1:0] sum_d;
  logic [SQ_W-1:0]   sqsum_d;
  logic [VAR_W-1:0]  prod_area_d;
  logic [VAR_W-1:0]  prod_sum_d;
  logic [VAR_W:0]    diff_d;

  // The store is wiped while in reset and during the one-cycle S_Reset pass;
  // the clear takes priority over any write presented in that cycle.
  always_comb begin
    store_clr_d = 1'b0;
    if (!resetn) begin
      store_clr_d = 1'b1;
    end else if (state_q == S_Reset) begin
      store_clr_d = 1'b1;
    end else begin
      store_clr_d = 1'b0;
    end
  end

  // Corner store: independent integral and squared write ports, each landing
  // in the bank named by dblBuf_i.
  always_ff @(posedge clk) begin
    if (store_clr_d) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 4; a++) begin
          int_q[b][a] <= {DATA_W{1'b0}};
          sq_q[b][a]  <= {SQ_W{1'b0}};
        end
      end
    end else begin
      if (we_i) begin
        int_q[dblBuf_i][waddr_i] <= wdata_i;
      end
      if (weSQ_i) begin
        sq_q[dblBuf_i][waddrSQ_i] <= wdataSQ_i;
      end
    end
  end

  // Rectangle sums from the selected bank.  Wrap-around is intentional: the
  // true rectangle sum always fits, so modular arithmetic recovers it.
  always_comb begin
    sum_d   = int_q[sel_q][CORNER_D] - int_q[sel_q][CORNER_B]
            - int_q[sel_q][CORNER_C] + int_q[sel_q][CORNER_A];
    sqsum_d = sq_q[sel_q][CORNER_D] - sq_q[sel_q][CORNER_B]
            - sq_q[sel_q][CORNER_C] + sq_q[sel_q][CORNER_A];
  end

  // Zero-extended products from registered operands, and the signed
  // difference with one guard bit so a negative raw result is visible.
  always_comb begin
    prod_area_d = VAR_W'(area_q) * VAR_W'(sqsum_q);
    prod_sum_d  = VAR_W'(sum_q) * VAR_W'(sum_q);
    diff_d      = {1'b0, prod_area_q} - {1'b0, prod_sum_q};
  end

  // Datapath pipeline.  S_Sum is a settle cycle so a write on the edge that
  // enters S_Mul1 is still part of the snapshot; the operands are captured on
  // the S_Mul1 edge and products on the S_Mul2 edge.  Later writes to the
  // store cannot disturb the result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sum_q       <= {DATA_W{1'b0}};
      sqsum_q     <= {SQ_W{1'b0}};
      prod_area_q <= {VAR_W{1'b0}};
      prod_sum_q  <= {VAR_W{1'b0}};
    end else begin
      case (state_q)
        S_Mul1: begin
          sum_q   <= sum_d;
          sqsum_q <= sqsum_d;
        end
        S_Mul2: begin
          prod_area_q <= prod_area_d;
          prod_sum_q  <= prod_sum_d;
        end
        default: begin
          sum_q       <= sum_q;
          sqsum_q     <= sqsum_q;
          prod_area_q <= prod_area_q;
          prod_sum_q  <= prod_sum_q;
        end
      endcase
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_Reset;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      variance_q <= {VAR_W{1'b0}};
      negClamp_q <= 1'b0;
      sel_q      <= 1'b0;
      area_q     <= {AREA_W{1'b0}};
    end else begin
      case (state_q)
        S_Reset: begin
          variance_q <= {VAR_W{1'b0}};
          negClamp_q <= 1'b0;
          sel_q      <= 1'b0;
          area_q     <= {AREA_W{1'b0}};
          done_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= S_Ready;
        end
        S_Ready: begin
          if (start_i) begin
            sel_q   <= bufSel_i;
            area_q  <= area_i;
            ready_q <= 1'b0;
            state_q <= S_Sum;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_Ready;
          end
        end
        S_Sum: begin
          state_q <= S_Mul1;
        end
        S_Mul1: begin
          state_q <= S_Mul2;
        end
        S_Mul2: begin
          state_q <= S_Sub;
        end
        S_Sub: begin
          if (diff_d[VAR_W]) begin
            variance_q <= {VAR_W{1'b0}};
            negClamp_q <= 1'b1;
          end else begin
            variance_q <= diff_d[VAR_W-1:0];
            negClamp_q <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= S_Done;
        end
        S_Done: begin
          if (ack_i) begin
            done_q  <= 1'b0;
            state_q <= S_Reset;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_Done;
          end
        end
        default: begin
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_Reset;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign variance_o = variance_q;
  assign negClamp_o = negClamp_q;

endmodule

// File: tb/tb_variance_calc.sv
// Self-checking bench for variance_calc: directed vector table, hand-written
// timing sequences, and randomized traffic against a behavioural model.
module tb_variance_calc;

  localparam int DATA_W = 32;
  localparam int SQ_W   = 48;
  localparam int AREA_W = 16;
  localparam int VAR_W  = 64;

  logic              clk;
  logic              resetn;
  logic              we;
  logic [1:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic              weSQ;
  logic [1:0]        waddrSQ;
  logic [SQ_W-1:0]   wdataSQ;
  logic              dblBuf;
  logic              start;
  logic              bufSel;
  logic [AREA_W-1:0] area;
  logic              ack;
  logic              ready;
  logic              done;
  logic [VAR_W-1:0]  variance;
  logic              negClamp;

  variance_calc #(
    .DATA_W(DATA_W), .SQ_W(SQ_W), .AREA_W(AREA_W), .VAR_W(VAR_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .weSQ_i(weSQ), .waddrSQ_i(waddrSQ), .wdataSQ_i(wdataSQ),
    .dblBuf_i(dblBuf), .start_i(start), .bufSel_i(bufSel), .area_i(area),
    .ack_i(ack), .ready_o(ready), .done_o(done),
    .variance_o(variance), .negClamp_o(negClamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model of the corner store.
  logic [31:0] mi [0:1][0:3];
  logic [47:0] ms [0:1][0:3];
  bit          clr_next;

  typedef struct {
    bit               bank;
    logic [3:0][31:0] iv;   // [3]=D [2]=C [1]=B [0]=A
    logic [3:0][47:0] sv;
    logic [15:0]      ar;
    logic [63:0]      ev;
    bit               en;
  } vec_t;

  vec_t tab [0:6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic void model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 4; a++) begin
        mi[b][a] = 32'd0;
        ms[b][a] = 48'd0;
      end
  endfunction

  // Expected result: area*sqsum - sum^2 with modular corner sums, clamped.
  function automatic void model_result(input bit b, input logic [15:0] ar,
                                       output logic [63:0] v, output bit n);
    logic [31:0]  s;
    logic [47:0]  q;
    logic [127:0] pa;
    logic [127:0] ps;
    s  = mi[b][3] - mi[b][1] - mi[b][2] + mi[b][0];
    q  = ms[b][3] - ms[b][1] - ms[b][2] + ms[b][0];
    pa = 128'(ar) * 128'(q);
    ps = 128'(s) * 128'(s);
    if (pa < ps) begin
      v = 64'd0;
      n = 1'b1;
    end else begin
      v = 64'(pa - ps);
      n = 1'b0;
    end
  endfunction

  // One clock: model follows the store rules at the edge, then sample at +1.
  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      model_clear();
      clr_next = 1'b1;
    end else if (clr_next) begin
      model_clear();
      clr_next = 1'b0;
    end else begin
      if (we)   mi[dblBuf][waddr]   = wdata;
      if (weSQ) ms[dblBuf][waddrSQ] = wdataSQ;
    end
    #1;
  endtask

  task automatic no_writes();
    we   = 1'b0;
    weSQ = 1'b0;
  endtask

  task automatic rand_writes();
    we      = 1'($urandom_range(0, 1));
    weSQ    = 1'($urandom_range(0, 1));
    waddr   = 2'($urandom_range(0, 3));
    waddrSQ = 2'($urandom_range(0, 3));
    dblBuf  = 1'($urandom_range(0, 1));
    wdata   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
    wdataSQ = ($urandom_range(0, 1) != 0) ? {16'($urandom), $urandom}
                                          : 48'($urandom_range(0, 65535));
  endtask

  task automatic load_bank(input bit b, input logic [3:0][31:0] iv, input logic [3:0][47:0] sv);
    for (int a = 0; a < 4; a++) begin
      we = 1'b1; weSQ = 1'b1; dblBuf = b;
      waddr = 2'(a); waddrSQ = 2'(a);
      wdata = iv[a]; wdataSQ = sv[a];
      tick();
    end
    no_writes();
  endtask

  task automatic noise(input bit noisy, input bit bs, input bit with_ack);
    if (noisy) begin
      start  = 1'($urandom_range(0, 1));
      bufSel = ~bs;
      area   = 16'($urandom);
      ack    = with_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // Full compute transaction from S_Ready back to S_Ready.
  task automatic run_calc(input bit bs, input logic [15:0] ar, input bit use_tab,
                          input logic [63:0] tv, input bit tn, input bit rnd_wr,
                          input bit noisy, input bit lw, input int hold, input string nm);
    logic [63:0] ev;
    bit          en;
    chk({nm, ":ready_pre"}, 64'(ready), 64'd1);
    start = 1'b1; bufSel = bs; area = ar; ack = 1'b0;
    if (rnd_wr) rand_writes(); else no_writes();
    tick();                                   // edge k
    start = 1'b0;
    chk({nm, ":ready_fall"}, 64'(ready), 64'd0);
    chk({nm, ":done_k"}, 64'(done), 64'd0);
    if (lw) begin
      we = 1'b1; weSQ = 1'b0; dblBuf = 1'b0; waddr = 2'd3; wdata = 32'd61;
    end else if (rnd_wr) rand_writes(); else no_writes();
    noise(noisy, bs, 1'b1);
    tick();                                   // edge k+1: snapshot
    model_result(bs, ar, ev, en);
    if (use_tab) begin
      ev = tv;
      en = tn;
    end
    chk({nm, ":done_k1"}, 64'(done), 64'd0);
    for (int i = 0; i < 2; i++) begin         // edges k+2, k+3
      if (lw && i == 0) begin
        we = 1'b1; wdata = 32'd99;
      end else if (rnd_wr) rand_writes(); else no_writes();
      noise(noisy, bs, 1'b1);
      tick();
      chk({nm, ":done_early"}, 64'(done), 64'd0);
    end
    if (rnd_wr) rand_writes(); else no_writes();
    noise(noisy, bs, 1'b1);
    tick();                                   // edge k+4
    chk({nm, ":done_rise"}, 64'(done), 64'd1);
    chk({nm, ":variance"}, variance, ev);
    chk({nm, ":negClamp"}, 64'(negClamp), 64'(en));
    ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (rnd_wr) rand_writes(); else no_writes();
      noise(noisy, bs, 1'b0);
      tick();
      chk({nm, ":hold_done"}, 64'(done), 64'd1);
      chk({nm, ":hold_var"}, variance, ev);
      chk({nm, ":hold_neg"}, 64'(negClamp), 64'(en));
    end
    ack = 1'b1; start = 1'b0;
    if (rnd_wr) rand_writes(); else no_writes();
    tick();                                   // edge m
    ack = 1'b0;
    clr_next = 1'b1;
    chk({nm, ":done_fall"}, 64'(done), 64'd0);
    chk({nm, ":ready_m"}, 64'(ready), 64'd0);
    if (rnd_wr) rand_writes(); else no_writes();
    tick();                                   // edge m+1: S_Reset pass
    chk({nm, ":ready_back"}, 64'(ready), 64'd1);
    chk({nm, ":var_clr"}, variance, 64'd0);
    chk({nm, ":neg_clr"}, 64'(negClamp), 64'd0);
    no_writes();
  endtask

  initial begin
    vec_t v;
    tab[0] = '{bank:1'b0, iv:{32'd60, 32'd20, 32'd10, 32'd0},
               sv:{48'd600, 48'd200, 48'd100, 48'd0}, ar:16'd4, ev:64'd300, en:1'b0};
    tab[1] = '{bank:1'b0, iv:{32'd60, 32'd20, 32'd10, 32'd0},
               sv:{48'd500, 48'd200, 48'd100, 48'd0}, ar:16'd4, ev:64'd0, en:1'b1};
    tab[2] = '{bank:1'b1, iv:{32'd8, 32'd0, 32'd0, 32'd0},
               sv:{48'd16, 48'd0, 48'd0, 48'd0}, ar:16'd4, ev:64'd0, en:1'b0};
    tab[3] = '{bank:1'b0, iv:{32'h0000000F, 32'd0, 32'd0, 32'hFFFFFFF0},
               sv:{48'd0, 48'd0, 48'd0, 48'd0}, ar:16'd1, ev:64'd0, en:1'b1};
    tab[4] = '{bank:1'b1, iv:{32'd0, 32'd0, 32'hFFFFFFF0, 32'h00000010},
               sv:{48'd844, 48'hFFFFFFFFFE00, 48'd0, 48'hFFFFFFFFFF00},
               ar:16'd1, ev:64'd76, en:1'b0};
    tab[5] = '{bank:1'b0, iv:{32'd0, 32'd0, 32'd0, 32'd0},
               sv:{48'hFFFFFFFFFFFF, 48'd0, 48'd0, 48'd0}, ar:16'hFFFF,
               ev:64'hFFFEFFFFFFFF0001, en:1'b0};
    tab[6] = '{bank:1'b1, iv:{32'd4, 32'd0, 32'd0, 32'd0},
               sv:{48'd4, 48'd0, 48'd0, 48'd0}, ar:16'd4, ev:64'd0, en:1'b0};

    model_clear();
    clr_next = 1'b0;
    resetn = 1'b0; we = 1'b0; weSQ = 1'b0; waddr = 2'd0; waddrSQ = 2'd0;
    wdata = 32'd0; wdataSQ = 48'd0; dblBuf = 1'b0; start = 1'b0;
    bufSel = 1'b0; area = 16'd0; ack = 1'b0;

    // Power-on reset.
    repeat (3) tick();
    chk("rst:ready", 64'(ready), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:variance", variance, 64'd0);
    chk("rst:negClamp", 64'(negClamp), 64'd0);
    resetn = 1'b1;
    tick();
    chk("rst:ready_rise", 64'(ready), 64'd1);
    chk("rst:done_low", 64'(done), 64'd0);

    // Directed vectors; the other bank always carries decoy data.
    for (int i = 0; i < 7; i++) begin
      v = tab[i];
      load_bank(~v.bank, {32'd1000, 32'd3, 32'd2, 32'd1}, {48'd77, 48'd5, 48'd6, 48'd7});
      load_bank(v.bank, v.iv, v.sv);
      run_calc(v.bank, v.ar, 1'b1, v.ev, v.en, 1'b0, 1'b0, 1'b0, 0, $sformatf("vec%0d", i));
    end

    // Snapshot boundary: D=61 on edge k+1 counts, D=99 on edge k+2 does not.
    load_bank(1'b0, {32'd60, 32'd20, 32'd10, 32'd0}, {48'd600, 48'd200, 48'd100, 48'd0});
    load_bank(1'b1, {32'd8, 32'd0, 32'd0, 32'd0}, {48'd16, 48'd0, 48'd0, 48'd0});
    run_calc(1'b0, 16'd4, 1'b1, 64'd239, 1'b0, 1'b0, 1'b0, 1'b1, 0, "late_wr");

    // Long hold with ignored start/ack pulses during the busy states.
    load_bank(1'b0, {32'd60, 32'd20, 32'd10, 32'd0}, {48'd600, 48'd200, 48'd100, 48'd0});
    run_calc(1'b0, 16'd4, 1'b1, 64'd300, 1'b0, 1'b0, 1'b1, 1'b0, 10, "hold");

    // Reset during S_Mul1: result discarded, store cleared.
    load_bank(1'b0, {32'd60, 32'd20, 32'd10, 32'd0}, {48'd600, 48'd200, 48'd100, 48'd0});
    start = 1'b1; bufSel = 1'b0; area = 16'd4;
    tick();
    start = 1'b0;
    tick();
    resetn = 1'b0;
    we = 1'b1; dblBuf = 1'b0; waddr = 2'd3; wdata = 32'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst:done", 64'(done), 64'd0);
      chk("midrst:ready", 64'(ready), 64'd0);
      chk("midrst:variance", variance, 64'd0);
    end
    no_writes();
    resetn = 1'b1;
    tick();
    chk("midrst:ready_rise", 64'(ready), 64'd1);
    chk("midrst:done_low", 64'(done), 64'd0);
    chk("midrst:negClamp", 64'(negClamp), 64'd0);
    run_calc(1'b0, 16'd4, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_rst");

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      int nw;
      nw = int'($urandom_range(4, 12));
      for (int j = 0; j < nw; j++) begin
        rand_writes();
        tick();
      end
      no_writes();
      run_calc(1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(1, 64)),
               1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, int'($urandom_range(0, 3)),
               $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
